// File: rtl/iob_eth_arb_pkg.sv
// Shared types and constants for the iob_ethoc register-port arbiter.
package iob_eth_arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    localparam int MIDX_W = 1;

    localparam logic [31:0] ARB_TIMEOUT_RDATA = 32'hDEADBEEF;

endpackage

// File: rtl/iob_eth_arb_rr.sv
// Combinational two-way round-robin pick: on a tie the master that did not win last time is chosen.
module iob_eth_arb_rr
    import iob_eth_arb_pkg::*;
(
    input  logic [1:0]        valid_i,
    input  logic [MIDX_W-1:0] last_grant_i,
    output logic [MIDX_W-1:0] grant_o,
    output logic              any_o
);

    always_comb begin
        any_o = |valid_i;
        if (&valid_i) begin
            grant_o = ~last_grant_i;
        end else begin
            grant_o = valid_i[1];
        end
    end

endmodule

// File: rtl/iob_reg.sv
// Plain register with asynchronous active-high reset to a parameterised value.
module iob_reg #(
    parameter int             W       = 1,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk_i,
    input  logic         arst_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            q_o <= RST_VAL;
        end else begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/iob_eth_bus_arb.sv
// Two-master round-robin arbiter in front of the iob_ethoc IOb register port.
// Optional watchdog: define IOB_ETH_ARB_TIMEOUT_EN to complete stuck accesses with a dummy read.
module iob_eth_bus_arb
    import iob_eth_arb_pkg::*;
#(
    parameter int ADDR_W    = 16,
`ifdef IOB_ETH_ARB_TIMEOUT_EN
    parameter int TIMEOUT_W = 8,
`endif
    parameter int DATA_W    = 32
) (
    input  logic                clk_i,
    input  logic                arst_i,
    input  logic                m0_valid,
    input  logic [ADDR_W-1:0]   m0_address,
    input  logic [DATA_W-1:0]   m0_wdata,
    input  logic [DATA_W/8-1:0] m0_wstrb,
    output logic [DATA_W-1:0]   m0_rdata,
    output logic                m0_ready,
    input  logic                m1_valid,
    input  logic [ADDR_W-1:0]   m1_address,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_wstrb,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic                m1_ready,
    output logic                s_valid,
    output logic [ADDR_W-1:0]   s_address,
    output logic [DATA_W-1:0]   s_wdata,
    output logic [DATA_W/8-1:0] s_wstrb,
    input  logic [DATA_W-1:0]   s_rdata,
    input  logic                s_ready
`ifdef IOB_ETH_ARB_TIMEOUT_EN
    ,
    output logic                timeout_o
`endif
);

    logic [0:0]        state_raw_q;
    arb_state_t        state_q;
    arb_state_t        state_d;
    logic [MIDX_W-1:0] grant_q, grant_d;
    logic [MIDX_W-1:0] last_q, last_d;
    logic [MIDX_W-1:0] rr_grant;
    logic              rr_any;
    logic              busy, gnt_valid, done, finish, abort;
    logic [DATA_W-1:0] resp_data;

    iob_eth_arb_rr u_rr (
        .valid_i      ({m1_valid, m0_valid}),
        .last_grant_i (last_q),
        .grant_o      (rr_grant),
        .any_o        (rr_any)
    );

    assign state_q   = arb_state_t'(state_raw_q);
    assign busy      = (state_q == ARB_BUSY);
    assign gnt_valid = grant_q[0] ? m1_valid : m0_valid;
    assign done      = busy & gnt_valid & s_ready;
    // A master dropping valid mid-access is a protocol abort: no completion, fairness untouched.
    assign abort     = busy & ~gnt_valid;

`ifdef IOB_ETH_ARB_TIMEOUT_EN
    localparam logic [DATA_W-1:0] TO_RDATA = DATA_W'(ARB_TIMEOUT_RDATA);

    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
    logic                 expire;

    // s_ready in the expiry cycle takes priority, so expire excludes it.
    assign expire    = busy & gnt_valid & ~s_ready & (cnt_q == {TIMEOUT_W{1'b1}});
    assign cnt_d     = busy ? cnt_q + TIMEOUT_W'(1) : '0;
    assign finish    = done | expire;
    assign resp_data = expire ? TO_RDATA : s_rdata;
    assign timeout_o = expire;

    iob_reg #(.W(TIMEOUT_W), .RST_VAL('0)) u_cnt_reg (
        .clk_i  (clk_i),
        .arst_i (arst_i),
        .d_i    (cnt_d),
        .q_o    (cnt_q)
    );
`else
    assign finish    = done;
    assign resp_data = s_rdata;
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        if (!busy) begin
            if (rr_any) begin
                state_d = ARB_BUSY;
                grant_d = rr_grant;
            end
        end else if (finish) begin
            state_d = ARB_IDLE;
            last_d  = grant_q;
        end else if (abort) begin
            state_d = ARB_IDLE;
        end
    end

    iob_reg #(.W(1), .RST_VAL(1'b0)) u_state_reg (
        .clk_i  (clk_i),
        .arst_i (arst_i),
        .d_i    (state_d),
        .q_o    (state_raw_q)
    );

    iob_reg #(.W(MIDX_W), .RST_VAL('0)) u_grant_reg (
        .clk_i  (clk_i),
        .arst_i (arst_i),
        .d_i    (grant_d),
        .q_o    (grant_q)
    );

    // Resetting last_grant to m1 lets m0 win the first tie.
    iob_reg #(.W(MIDX_W), .RST_VAL(MIDX_W'(1))) u_last_reg (
        .clk_i  (clk_i),
        .arst_i (arst_i),
        .d_i    (last_d),
        .q_o    (last_q)
    );

    always_comb begin
        s_valid   = busy & gnt_valid;
        s_address = '0;
        s_wdata   = '0;
        s_wstrb   = '0;
        if (busy) begin
            s_address = grant_q[0] ? m1_address : m0_address;
            s_wdata   = grant_q[0] ? m1_wdata   : m0_wdata;
            s_wstrb   = grant_q[0] ? m1_wstrb   : m0_wstrb;
        end
        m0_ready = finish & ~grant_q[0];
        m1_ready = finish &  grant_q[0];
        m0_rdata = m0_ready ? resp_data : '0;
        m1_rdata = m1_ready ? resp_data : '0;
    end

endmodule
